// File: rtl/sha256_w_mem_reverse_iter.sv
// Runs the SHA-256 message schedule window backwards by up to 48 steps.
// Define SHA256_REV_PAD_CHECK_EN to get a pad_ok flag that is registered when the final v15 is 32'h00000280.
module sha256_w_mem_reverse_iter (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  logic [5:0]   steps,
   input  logic [511:0] window_in,
   output logic         busy,
   output logic         done,
   output logic [511:0] window_out,
   output logic         pad_ok
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [5:0] MAX_STEPS = 6'd48;

   state_t       state, state_next;
   logic [5:0]   count, count_next;
   logic [511:0] window, window_next;
   logic [5:0]   steps_clamped;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Recover the word that the forward step shifted out of the top: v15 was W16, v0..v14 were W1..W15.
   function automatic logic [511:0] rev_step(input logic [511:0] w);
      logic [31:0] v0, v8, v13, v15, r;
      v0  = w[511:480];
      v8  = w[255:224];
      v13 = w[95:64];
      v15 = w[31:0];
      r   = v15 - sig1(v13) - v8 - sig0(v0);
      return {r, w[511:32]};
   endfunction

   assign steps_clamped = (steps > MAX_STEPS) ? MAX_STEPS : steps;

   // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
   always_comb begin
      state_next  = state;
      count_next  = count;
      window_next = window;
      unique case (state)
         IDLE, DONE: begin
            if (state == DONE) state_next = IDLE;
            if (start) begin
               window_next = window_in;
               count_next  = steps_clamped;
               state_next  = (steps_clamped != 6'd0) ? RUN : DONE;
            end
         end
         RUN: begin
            window_next = rev_step(window);
            count_next  = count - 6'd1;
            if (count == 6'd1) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state  <= IDLE;
         count  <= '0;
         window <= '0;
      end else begin
         state  <= state_next;
         count  <= count_next;
         window <= window_next;
      end
   end

   assign busy       = (state == RUN);
   assign done       = (state == DONE);
   assign window_out = window;

`ifdef SHA256_REV_PAD_CHECK_EN
   localparam logic [31:0] PAD_WORD = 32'h00000280;
   logic pad_q;

   // Evaluated on the edge that enters DONE, so the flag lines up with the done cycle.
   always_ff @(posedge CLK) begin
      if (!RST) pad_q <= 1'b0;
      else      pad_q <= (state_next == DONE) && (window_next[31:0] == PAD_WORD);
   end

   assign pad_ok = pad_q;
`else
   assign pad_ok = 1'b0;
`endif

endmodule

// File: doc/sha256_w_mem_reverse_iter.md
SHA256_W_MEM_REVERSE_ITER -- requirements
Module: sha256_w_mem_reverse_iter

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST  input  1  synchronous active-low reset.
REQ-004 start  input  1  request to load window_in and begin reverse iteration; sampled on the CLK rising edge.
REQ-005 steps  input  6  number of reverse schedule steps N, sampled with start.
REQ-006 window_in  input  512  16-word schedule window {v0..v15}, with v0 in [511:480] and v15 in [31:0].
REQ-007 busy  output  1  high while reverse steps are in progress.
REQ-008 done  output  1  one-cycle pulse when window_out holds the final result.
REQ-009 window_out  output  512  current window register.
REQ-010 pad_ok  output  1  padding-constant check flag (see Configuration).

Function
REQ-011 Each reverse step SHALL compute r = v15 - s1(v13) - v8 - s0(v0) modulo 2^32, then load window {r, v0..v14}; this exactly undoes one forward schedule step.
REQ-012 s0(x) SHALL equal ROTR7(x) ^ ROTR18(x) ^ (x >> 3); s1(x) SHALL equal ROTR17(x) ^ ROTR19(x) ^ (x >> 10).
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE with start=1: load window_in and count=min(steps,48); go to RUN if count>0, otherwise go to DONE.
REQ-015 In RUN, each edge SHALL perform one step and decrement count; the edge that performs the last step SHALL move the FSM to DONE.
REQ-016 DONE SHALL last one cycle, with done=1, and then go to IDLE unless start is accepted in that cycle.
REQ-017 Latency: done SHALL be high exactly N+1 edges after the edge that samples start, for every N in 0..48.
REQ-018 steps values above 48 SHALL be clamped to 48.
REQ-019 busy SHALL equal 1 only in RUN.
REQ-020 start SHALL be ignored while in RUN; window and count SHALL be unaffected.
REQ-021 window_out SHALL hold its value in IDLE and DONE until the next accepted start.
REQ-022 Arithmetic SHALL be 32-bit unsigned, wrap-around, with no carry or borrow output.

Reset
REQ-023 On RST=0 at a CLK edge: FSM=IDLE, count=0, window_out=0, busy=0, done=0, pad_ok=0.
REQ-024 Reset SHALL take priority over start and SHALL abort RUN mid-operation with no done pulse.
REQ-025 The first start SHALL be accepted on the first edge with RST=1.

Configuration
REQ-026 Macro SHA256_REV_PAD_CHECK_EN: when defined, pad_ok SHALL be registered high together with done when the final window word v15 equals 32'h00000280. Otherwise pad_ok SHALL be 0 while done is high.
REQ-027 With SHA256_REV_PAD_CHECK_EN defined, pad_ok SHALL clear on the cycle after done.
REQ-028 Without SHA256_REV_PAD_CHECK_EN, pad_ok SHALL be tied to 0 and no comparator SHALL be synthesised.

Verification
REQ-029 window_in: v15=32'h00000280, all other words 0; steps=1 -> done at edge 2; window_out={32'h00000280, 15 words of 0}.
REQ-030 window_in: v0=32'h00000001, all other words 0; steps=1 -> window_out[511:480]=32'hFDFFC000, window_out[479:448]=32'h00000001, remaining words 0.
REQ-031 steps=0, arbitrary window_in -> done at edge 1; window_out=window_in; busy never high.
REQ-032 Round trip: apply a random W0..W15 to a forward-model bench, run 16 forward steps, feed the result with steps=16 -> window_out equals the original W0..W15; done at edge 17.
REQ-033 steps=63 -> clamped; done at edge 49. Then start asserted mid-RUN -> ignored.
REQ-034 RST=0 at RUN cycle 5 -> all outputs 0 on the next edge and no done pulse. With SHA256_REV_PAD_CHECK_EN defined and a final v15 of 32'h00000280 -> pad_ok=1 only in the done cycle.
